ghost_map_updater: RTL

Maintains the ghost markers in the shared map RAM, the write-side counterpart of the collision detector that reads and clears those markers. When a ghost moves, the block does a read-modify-write on the map word for the destination cell, which adds the ghost marker while keeping any dot or pill underneath. It then does a read-modify-write on the word for the departed cell, which removes the marker and restores the dot or pill. It drives port B of the map RAM. The collision detector keeps port A.

---
 rtl/ghost_map_updater.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ghost_map_updater.sv
// Ghost marker writer for port B of the shared map RAM: sets the marker on the
// destination cell, then clears it from the departed cell, preserving dots/pills.
module ghost_map_updater #(
   parameter int COLS = 40
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic                move_req,
   input  logic [5:0]          old_x,
   input  logic [4:0]          old_y,
   input  logic [5:0]          new_x,
   input  logic [4:0]          new_y,
   input  logic [4*COLS-1:0]   ram_q,
   output logic [4:0]          ram_addr,
   output logic [4*COLS-1:0]   ram_wdata,
   output logic                ram_wren,
   output logic                busy,
   output logic                done,
   output logic                err
);

   // state   | meaning
   // IDLE    | waiting for move_req
   // RD_NEW  | destination row address presented
   // LAT_NEW | destination word arrives; wall check, build set word
   // WR_NEW  | destination word written
   // RD_OLD  | departed row address presented
   // LAT_OLD | departed word arrives; build clear word
   // WR_OLD  | departed word written
   // DONE    | done pulse (err qualifies it)

   localparam int W = 4*COLS;

   typedef enum logic [2:0] {
      IDLE, RD_NEW, LAT_NEW, WR_NEW, RD_OLD, LAT_OLD, WR_OLD, DONE
   } state_t;

   state_t     state;
   logic [5:0] ox, nx;
   logic [4:0] oy, ny;

   function automatic logic [3:0] field_get(input logic [W-1:0] w, input logic [5:0] x);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 0; i < COLS; i++)
         if (x == 6'(i)) r = w[W-4-4*i +: 4];
      return r;
   endfunction

   function automatic logic [W-1:0] field_put(input logic [W-1:0] w, input logic [5:0] x,
                                              input logic [3:0] c);
      logic [W-1:0] r;
      r = w;
      for (int i = 0; i < COLS; i++)
         if (x == 6'(i)) r[W-4-4*i +: 4] = c;
      return r;
   endfunction

   function automatic logic [3:0] set_code(input logic [3:0] c);
      logic [3:0] r;
      case (c)
         4'd0, 4'd4: r = 4'd5;
         4'd2:       r = 4'd6;
         4'd3:       r = 4'd7;
         default:    r = c;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] clr_code(input logic [3:0] c);
      logic [3:0] r;
      case (c)
         4'd5:    r = 4'd0;
         4'd6:    r = 4'd2;
         4'd7:    r = 4'd3;
         default: r = c;
      endcase
      return r;
   endfunction

   // ram_wdata doubles as the word buffer: it is loaded with the modified word
   // on the latch cycle so it is already valid during the write cycle.
   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         state     <= IDLE;
         ox        <= '0;
         oy        <= '0;
         nx        <= '0;
         ny        <= '0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_wren  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (move_req) begin
                  ox   <= old_x;
                  oy   <= old_y;
                  nx   <= new_x;
                  ny   <= new_y;
                  busy <= 1'b1;
                  if (int'(old_x) >= COLS || int'(new_x) >= COLS) begin
                     state <= DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else if (old_x == new_x && old_y == new_y) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= RD_NEW;
                     ram_addr <= new_y;
                  end
               end
            end
            RD_NEW: state <= LAT_NEW;
            LAT_NEW: begin
               if (field_get(ram_q, nx) == 4'd1) begin
                  state <= DONE;
                  done  <= 1'b1;
                  err   <= 1'b1;
               end else begin
                  ram_wdata <= field_put(ram_q, nx, set_code(field_get(ram_q, nx)));
                  ram_addr  <= ny;
                  ram_wren  <= 1'b1;
                  state     <= WR_NEW;
               end
            end
            WR_NEW: begin
               ram_wren <= 1'b0;
               ram_addr <= oy;
               state    <= RD_OLD;
            end
            RD_OLD: state <= LAT_OLD;
            LAT_OLD: begin
               ram_wdata <= field_put(ram_q, ox, clr_code(field_get(ram_q, ox)));
               ram_wren  <= 1'b1;
               state     <= WR_OLD;
            end
            WR_OLD: begin
               ram_wren <= 1'b0;
               done     <= 1'b1;
               state    <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               err   <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
